// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM stage: load/store funct3 values,
// FSM state type and base byte-strobe patterns.
package mem_stage_pkg;

   // Load funct3 encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Store funct3 encodings
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // Base strobe patterns, shifted by the byte offset for sb/sh
   localparam logic [3:0] STRB_B = 4'b0001;
   localparam logic [3:0] STRB_H = 4'b0011;
   localparam logic [3:0] STRB_W = 4'b1111;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mem_state_t;

endpackage

// File: rtl/mem_stage_align.sv
// mem_align: combinational store lane replication / byte strobes and
// load lane extraction with sign or zero extension.
module mem_align
   import mem_stage_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Store side: strobes and lane-replicated write data
   always_comb begin
      wstrb = '0;
      wdata = store_data;
      case (funct3)
         F3_SB: begin
            wstrb = STRB_B << addr_lo;
            wdata = {4{store_data[7:0]}};
         end
         F3_SH: begin
            wstrb = STRB_H << addr_lo;
            wdata = {2{store_data[15:0]}};
         end
         F3_SW: begin
            wstrb = STRB_W;
            wdata = store_data;
         end
         default: begin
            wstrb = '0;
            wdata = store_data;
         end
      endcase
   end

   // Load side: pick the addressed byte/half and extend to 32 bits
   always_comb begin
      case (addr_lo)
         2'd0:    lane_b = load_word[7:0];
         2'd1:    lane_b = load_word[15:8];
         2'd2:    lane_b = load_word[23:16];
         default: lane_b = load_word[31:24];
      endcase
      lane_h = addr_lo[1] ? load_word[31:16] : load_word[15:0];
      case (funct3)
         F3_LB:   load_data = {{24{lane_b[7]}}, lane_b};
         F3_LBU:  load_data = {24'd0, lane_b};
         F3_LH:   load_data = {{16{lane_h[15]}}, lane_h};
         F3_LHU:  load_data = {16'd0, lane_h};
         F3_LW:   load_data = load_word;
         default: load_data = '0;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: alignment checks, data-memory req/ack handshake
// with timeout, MEM/WB register and stall back to EX.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_store_data,
   input  logic [2:0]  ex_funct3,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic [4:0]  ex_rd,
   input  logic        ex_reg_write,
   output logic        mem_stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rd,
   output logic        wb_reg_write,
   output logic        wb_misaligned,
   output logic        wb_bus_err
);

   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   mem_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      addr_q, addr_d;
   logic [2:0]       f3_q, f3_d;
   logic [4:0]       rd_q, rd_d;
   logic             regw_q, regw_d;
   logic             we_q, we_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       wstrb_q, wstrb_d;
   logic             wb_valid_q, wb_valid_d;
   logic [31:0]      wb_data_q, wb_data_d;
   logic [4:0]       wb_rd_q, wb_rd_d;
   logic             wb_regw_q, wb_regw_d;
   logic             wb_mis_q, wb_mis_d;
   logic             wb_berr_q, wb_berr_d;

   logic             busy;
   logic             is_load, is_store, bad_access;
   logic [2:0]       al_f3;
   logic [1:0]       al_lo;
   logic [3:0]       al_wstrb;
   logic [31:0]      al_wdata, al_load;

   assign busy = (state_q == BUSY);

   // One aligner serves both phases: EX fields for stores in IDLE,
   // latched fields for load extraction in BUSY.
   assign al_f3 = busy ? f3_q : ex_funct3;
   assign al_lo = busy ? addr_q[1:0] : ex_alu_result[1:0];

   mem_align u_align (
      .funct3     (al_f3),
      .addr_lo    (al_lo),
      .store_data (ex_store_data),
      .load_word  (dmem_rdata),
      .wstrb      (al_wstrb),
      .wdata      (al_wdata),
      .load_data  (al_load)
   );

   // Classify the EX instruction: illegal funct3 or misaligned address
   always_comb begin
      is_load    = ex_mem_read;
      is_store   = ex_mem_write & ~ex_mem_read;
      bad_access = 1'b0;
      if (is_load) begin
         case (ex_funct3)
            F3_LW:         bad_access = (ex_alu_result[1:0] != 2'b00);
            F3_LH, F3_LHU: bad_access = ex_alu_result[0];
            F3_LB, F3_LBU: bad_access = 1'b0;
            default:       bad_access = 1'b1;
         endcase
      end else if (is_store) begin
         case (ex_funct3)
            F3_SW:   bad_access = (ex_alu_result[1:0] != 2'b00);
            F3_SH:   bad_access = ex_alu_result[0];
            F3_SB:   bad_access = 1'b0;
            default: bad_access = 1'b1;
         endcase
      end
   end

   // Next-state, request latching and MEM/WB register update
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      f3_d       = f3_q;
      rd_d       = rd_q;
      regw_d     = regw_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      wb_valid_d = 1'b0;
      wb_data_d  = wb_data_q;
      wb_rd_d    = wb_rd_q;
      wb_regw_d  = 1'b0;
      wb_mis_d   = 1'b0;
      wb_berr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (ex_valid) begin
               if (is_load || is_store) begin
                  if (bad_access) begin
                     wb_valid_d = 1'b1;
                     wb_mis_d   = 1'b1;
                     wb_data_d  = ex_alu_result;
                     wb_rd_d    = ex_rd;
                  end else begin
                     state_d = BUSY;
                     addr_d  = ex_alu_result;
                     f3_d    = ex_funct3;
                     rd_d    = ex_rd;
                     regw_d  = ex_reg_write;
                     we_d    = is_store;
                     wdata_d = is_store ? al_wdata : '0;
                     wstrb_d = is_store ? al_wstrb : '0;
                  end
               end else begin
                  wb_valid_d = 1'b1;
                  wb_data_d  = ex_alu_result;
                  wb_rd_d    = ex_rd;
                  wb_regw_d  = ex_reg_write;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q + CNT_W'(1);
            // Ack is tested first so an ack on the limit cycle completes cleanly
            if (dmem_ack) begin
               state_d    = IDLE;
               we_d       = 1'b0;
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_q;
               wb_data_d  = we_q ? '0 : al_load;
               wb_regw_d  = we_q ? 1'b0 : regw_q;
            end else if (cnt_q == CNT_LIMIT) begin
               state_d    = IDLE;
               we_d       = 1'b0;
               wb_valid_d = 1'b1;
               wb_berr_d  = 1'b1;
               wb_rd_d    = rd_q;
               wb_data_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and pipeline registers, asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         f3_q       <= '0;
         rd_q       <= '0;
         regw_q     <= 1'b0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         wb_rd_q    <= '0;
         wb_regw_q  <= 1'b0;
         wb_mis_q   <= 1'b0;
         wb_berr_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         f3_q       <= f3_d;
         rd_q       <= rd_d;
         regw_q     <= regw_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         wb_valid_q <= wb_valid_d;
         wb_data_q  <= wb_data_d;
         wb_rd_q    <= wb_rd_d;
         wb_regw_q  <= wb_regw_d;
         wb_mis_q   <= wb_mis_d;
         wb_berr_q  <= wb_berr_d;
      end
   end

   assign mem_stall     = busy;
   assign dmem_req      = busy;
   assign dmem_we       = we_q;
   assign dmem_addr     = {addr_q[31:2], 2'b00};
   assign dmem_wdata    = wdata_q;
   assign dmem_wstrb    = wstrb_q;
   assign wb_valid      = wb_valid_q;
   assign wb_data       = wb_data_q;
   assign wb_rd         = wb_rd_q;
   assign wb_reg_write  = wb_regw_q;
   assign wb_misaligned = wb_mis_q;
   assign wb_bus_err    = wb_berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed test-plan steps followed by
// randomized operations against an arithmetic reference model.
module tb_mem_stage;
   localparam int T = 4;

   logic        clk;
   logic        rst_n;
   logic        ex_valid;
   logic [31:0] ex_alu_result;
   logic [31:0] ex_store_data;
   logic [2:0]  ex_funct3;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        mem_stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_reg_write;
   logic        wb_misaligned;
   logic        wb_bus_err;

   int checks = 0;
   int errors = 0;

   mem_stage #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ex_valid      (ex_valid),
      .ex_alu_result (ex_alu_result),
      .ex_store_data (ex_store_data),
      .ex_funct3     (ex_funct3),
      .ex_mem_read   (ex_mem_read),
      .ex_mem_write  (ex_mem_write),
      .ex_rd         (ex_rd),
      .ex_reg_write  (ex_reg_write),
      .mem_stall     (mem_stall),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_wdata    (dmem_wdata),
      .dmem_wstrb    (dmem_wstrb),
      .dmem_ack      (dmem_ack),
      .dmem_rdata    (dmem_rdata),
      .wb_valid      (wb_valid),
      .wb_data       (wb_data),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .wb_misaligned (wb_misaligned),
      .wb_bus_err    (wb_bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: expected load result from the rules in plain arithmetic
   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
      logic [31:0] v;
      int unsigned off;
      off = addr % 4;
      if (f3[1:0] == 2'd0) begin
         v = (rdata >> (8 * off)) & 32'hFF;
         if (!f3[2] && v >= 128) v = v - 32'd256;
      end else if (f3[1:0] == 2'd1) begin
         v = (rdata >> (16 * (off / 2))) & 32'hFFFF;
         if (!f3[2] && v >= 32768) v = v - 32'd65536;
      end else begin
         v = rdata;
      end
      return v;
   endfunction

   // Issue one instruction and follow it to retirement
   task automatic do_op(input bit rd_op, input bit wr_op, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] rd, input bit regw, input int ack_dly,
                        input logic [31:0] rdata);
      int unsigned sz, off, nbytes;
      bit          bad;
      logic [31:0] exp_wd, exp_strb32;
      sz  = f3[1:0];
      off = addr % 4;
      bad = 1'b0;
      if (rd_op) bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      else if (wr_op) bad = (f3 > 3'd2);
      if ((rd_op || wr_op) && !bad) bad = (addr % (1 << sz)) != 0;

      ex_valid      = 1'b1;
      ex_alu_result = addr;
      ex_store_data = sdata;
      ex_funct3     = f3;
      ex_mem_read   = rd_op;
      ex_mem_write  = wr_op;
      ex_rd         = rd;
      ex_reg_write  = regw;
      @(posedge clk); #1;

      if (!(rd_op || wr_op)) begin
         chk("alu_wb_valid", 32'(wb_valid), 32'd1);
         chk("alu_wb_data", wb_data, addr);
         chk("alu_wb_rd", 32'(wb_rd), 32'(rd));
         chk("alu_wb_regw", 32'(wb_reg_write), 32'(regw));
         chk("alu_flags", {30'd0, wb_misaligned, wb_bus_err}, 32'd0);
         chk("alu_no_req", 32'(dmem_req), 32'd0);
      end else if (bad) begin
         chk("mis_wb_valid", 32'(wb_valid), 32'd1);
         chk("mis_flag", 32'(wb_misaligned), 32'd1);
         chk("mis_berr", 32'(wb_bus_err), 32'd0);
         chk("mis_regw", 32'(wb_reg_write), 32'd0);
         chk("mis_no_req", 32'(dmem_req), 32'd0);
         chk("mis_no_stall", 32'(mem_stall), 32'd0);
      end else begin
         nbytes     = 1 << sz;
         exp_strb32 = wr_op ? (((32'd1 << nbytes) - 1) << off) : 32'd0;
         if (sz == 0)      exp_wd = (sdata & 32'hFF) * 32'h0101_0101;
         else if (sz == 1) exp_wd = (sdata & 32'hFFFF) * 32'h0001_0001;
         else              exp_wd = sdata;
         chk("acc_stall", 32'(mem_stall), 32'd1);
         chk("acc_req", 32'(dmem_req), 32'd1);
         chk("acc_we", 32'(dmem_we), 32'(wr_op));
         chk("acc_addr", dmem_addr, addr - off);
         chk("acc_wstrb", 32'(dmem_wstrb), exp_strb32);
         if (wr_op) chk("acc_wdata", dmem_wdata, exp_wd);
         chk("acc_wb_idle", 32'(wb_valid), 32'd0);
         for (int k = 0; k < T; k++) begin
            if (k == ack_dly) begin
               dmem_ack   = 1'b1;
               dmem_rdata = rdata;
            end
            @(posedge clk); #1;
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
            if (k == ack_dly) begin
               chk("ret_wb_valid", 32'(wb_valid), 32'd1);
               chk("ret_flags", {30'd0, wb_misaligned, wb_bus_err}, 32'd0);
               chk("ret_regw", 32'(wb_reg_write), rd_op ? 32'(regw) : 32'd0);
               if (rd_op) begin
                  chk("ret_data", wb_data, model_load(f3, addr, rdata));
                  chk("ret_rd", 32'(wb_rd), 32'(rd));
               end
               chk("ret_req_low", 32'(dmem_req), 32'd0);
               chk("ret_stall_low", 32'(mem_stall), 32'd0);
               break;
            end else if (k == T - 1) begin
               chk("to_wb_valid", 32'(wb_valid), 32'd1);
               chk("to_bus_err", 32'(wb_bus_err), 32'd1);
               chk("to_mis", 32'(wb_misaligned), 32'd0);
               chk("to_regw", 32'(wb_reg_write), 32'd0);
               chk("to_req_low", 32'(dmem_req), 32'd0);
               chk("to_stall_low", 32'(mem_stall), 32'd0);
            end else begin
               chk("wait_req", 32'(dmem_req), 32'd1);
               chk("wait_stall", 32'(mem_stall), 32'd1);
               chk("wait_addr", dmem_addr, addr - off);
               chk("wait_wstrb", 32'(dmem_wstrb), exp_strb32);
               chk("wait_wb_idle", 32'(wb_valid), 32'd0);
            end
         end
      end
      ex_valid     = 1'b0;
      ex_mem_read  = 1'b0;
      ex_mem_write = 1'b0;
   endtask

   task automatic idle_cycle(input bit pulse_ack);
      ex_valid = 1'b0;
      dmem_ack = pulse_ack;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      chk("idle_wb_valid", 32'(wb_valid), 32'd0);
      chk("idle_req", 32'(dmem_req), 32'd0);
      chk("idle_stall", 32'(mem_stall), 32'd0);
   endtask

   initial begin
      rst_n         = 1'b0;
      ex_valid      = 1'b0;
      ex_alu_result = '0;
      ex_store_data = '0;
      ex_funct3     = '0;
      ex_mem_read   = 1'b0;
      ex_mem_write  = 1'b0;
      ex_rd         = '0;
      ex_reg_write  = 1'b0;
      dmem_ack      = 1'b0;
      dmem_rdata    = '0;
      #1;
      chk("rst_outputs", {25'd0, mem_stall, dmem_req, dmem_we, wb_valid, wb_reg_write,
                          wb_misaligned, wb_bus_err}, 32'd0);
      chk("rst_addr", dmem_addr, 32'd0);
      chk("rst_wstrb", 32'(dmem_wstrb), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // add, sb with ack on 4th busy cycle, loads, misaligned lw
      do_op(0, 0, 3'd0, 32'h0000_1234, 32'd0, 5'd5, 1, 0, 32'd0);
      do_op(0, 1, 3'd0, 32'h0000_0103, 32'h0000_00AB, 5'd0, 0, 3, 32'd0);
      do_op(1, 0, 3'd0, 32'h0000_0102, 32'd0, 5'd7, 1, 1, 32'h00F0_0000);
      do_op(1, 0, 3'd4, 32'h0000_0102, 32'd0, 5'd7, 1, 0, 32'h00F0_0000);
      do_op(1, 0, 3'd5, 32'h0000_0102, 32'd0, 5'd8, 1, 2, 32'h8001_0000);
      do_op(1, 0, 3'd2, 32'h0000_0102, 32'd0, 5'd9, 1, 0, 32'd0);
      idle_cycle(1'b0);
      // timeout and ack on the limit cycle
      do_op(1, 0, 3'd2, 32'h0000_0200, 32'd0, 5'd3, 1, 99, 32'd0);
      do_op(1, 0, 3'd2, 32'h0000_0204, 32'd0, 5'd3, 1, T - 1, 32'hCAFE_F00D);
      idle_cycle(1'b1);
      do_op(0, 1, 3'd1, 32'h0000_0302, 32'h1234_BEEF, 5'd0, 0, 0, 32'd0);
      do_op(0, 1, 3'd2, 32'h0000_0308, 32'hDEAD_BEEF, 5'd0, 0, 1, 32'd0);
      do_op(0, 1, 3'd3, 32'h0000_0308, 32'hDEAD_BEEF, 5'd0, 0, 0, 32'd0);
      do_op(1, 0, 3'd6, 32'h0000_0308, 32'd0, 5'd4, 1, 0, 32'd0);

      // asynchronous reset in the middle of BUSY
      ex_valid      = 1'b1;
      ex_alu_result = 32'h0000_0400;
      ex_funct3     = 3'd2;
      ex_mem_read   = 1'b1;
      ex_rd         = 5'd6;
      ex_reg_write  = 1'b1;
      @(posedge clk); #1;
      chk("arst_pre_req", 32'(dmem_req), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_req", 32'(dmem_req), 32'd0);
      chk("arst_stall", 32'(mem_stall), 32'd0);
      chk("arst_wb_valid", 32'(wb_valid), 32'd0);
      ex_valid    = 1'b0;
      ex_mem_read = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_op(0, 0, 3'd0, 32'h0000_0042, 32'd0, 5'd12, 1, 0, 32'd0);

      // randomized mix of ALU ops, loads and stores
      for (int i = 0; i < 60; i++) begin
         int unsigned kind;
         kind = $urandom_range(0, 2);
         do_op(kind == 1, kind == 2, 3'($urandom_range(0, 7)),
               32'h0000_1000 + 32'($urandom_range(0, 255)), $urandom,
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 5)), $urandom);
         if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
